// File: rtl/fft_sched_pkg.sv
// fft_sched_pkg
//   Shared definitions for the FFT frame scheduler:
//   - SRC_CH0 / SRC_CH1 : source identifiers (also the value stored in the tag FIFO)
//   - loadState_t       : load FSM encoding (IDLE -> GRANT -> LOAD -> IDLE)
//   - ceil_log2         : elaboration-time width helper
package fft_sched_pkg;

  localparam logic SRC_CH0 = 1'b0;
  localparam logic SRC_CH1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOAD  = 2'd2
  } loadState_t;

  function automatic int ceil_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fft_tag_fifo.sv
// fft_tag_fifo
//   Small FIFO of 1-bit source IDs, one entry per frame that has been loaded into the
//   FFT core and whose result has not yet been fully returned.
// Ports:
//   clk   in   clock, posedge
//   rst   in   asynchronous reset, active-high (FIFO empty)
//   push  in   enqueue din
//   pop   in   dequeue head
//   din   in   source ID to enqueue
//   full  out  DEPTH entries held
//   empty out  no entries held
//   head  out  oldest source ID
module fft_tag_fifo
  import fft_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = (ceil_log2(DEPTH) < 1) ? 1 : ceil_log2(DEPTH);
  localparam int CNT_W = ceil_log2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= din;
        wrPtr      <= nextPtr(wrPtr);
      end
      if (pop) rdPtr <= nextPtr(rdPtr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // The scheduler never pops an empty FIFO nor pushes a full one.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(pop && empty));
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler
//   Shares one in-place FFT core between two frame sources. A round-robin arbiter grants
//   a source, POINTS samples are streamed into the core while BUF_READY allows, and the
//   source ID of every loaded frame is queued. On the result side the core is told to
//   read out, results are forwarded one cycle later tagged with the queued source ID.
// Optional feature macro: FFT_SCHED_WDOG_EN
//   defined   -> 16-bit watchdog; if the tag FIFO is non-empty and no result sample arrives
//                for 0xFFFF cycles, ERR_SHORT pulses and the head tag is discarded.
//   undefined -> ERR_SHORT only from an early OUTP_READY fall.
// Ports:
//   CLK, RST                 clock / asynchronous active-high reset
//   SRC_REQ[1:0]             per-source frame request (held until granted)
//   SRC_VALID[1:0]           per-source sample available
//   SRC0_DATA, SRC1_DATA     source samples {im,re}
//   SRC_GNT[1:0]             one-hot grant, held for the whole frame load
//   SRC_POP[1:0]             sample-consumed strobe
//   FFT_BUF_READY            core can accept input samples
//   FFT_DATAI_VAL, FFT_DATAI sample into the core (combinational from the granted source)
//   FFT_OUTP_RDY             core has results to read
//   FFT_READ_OUTP            read request to the core
//   FFT_DATAO_VAL, FFT_DATAO result sample from the core
//   RES_READY                consumer can accept a result frame
//   RES_VALID, RES_DATA      result sample, one cycle after the core
//   RES_TAG                  source ID of the current result frame
//   RES_LAST                 marks the POINTS-th result sample
//   ERR_SHORT                1-cycle pulse when a result frame ended early
//   BUSY                     load in progress or results outstanding
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int POINTS   = 32,
  parameter int WIDTH    = 18,
  parameter int TAGDEPTH = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [1:0]         SRC_REQ,
  input  logic [1:0]         SRC_VALID,
  input  logic [2*WIDTH-1:0] SRC0_DATA,
  input  logic [2*WIDTH-1:0] SRC1_DATA,
  output logic [1:0]         SRC_GNT,
  output logic [1:0]         SRC_POP,
  input  logic               FFT_BUF_READY,
  output logic               FFT_DATAI_VAL,
  output logic [2*WIDTH-1:0] FFT_DATAI,
  input  logic               FFT_OUTP_RDY,
  output logic               FFT_READ_OUTP,
  input  logic               FFT_DATAO_VAL,
  input  logic [2*WIDTH-1:0] FFT_DATAO,
  input  logic               RES_READY,
  output logic               RES_VALID,
  output logic [2*WIDTH-1:0] RES_DATA,
  output logic               RES_TAG,
  output logic               RES_LAST,
  output logic               ERR_SHORT,
  output logic               BUSY
);

  localparam int CNT_W = (ceil_log2(POINTS) < 1) ? 1 : ceil_log2(POINTS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(POINTS - 1);

  loadState_t       state;
  logic             curSrc;     // granted source; between frames it is the RR pointer
  logic             pick;
  logic [CNT_W-1:0] inCnt;
  logic [CNT_W-1:0] outCnt;
  logic             selValid;
  logic             xfer;
  logic             tagPush;
  logic             tagPop;
  logic             tagFull;
  logic             tagEmpty;
  logic             tagHead;
  logic             outpRdy_p1;
  logic             shortErr;
  logic             frameDone;
  logic             wdogFire;

  // Both requesting: the one not served last. Otherwise whichever requests.
  assign pick = (SRC_REQ == 2'b11) ? ~curSrc : (SRC_REQ[1] ? SRC_CH1 : SRC_CH0);

  assign selValid      = (curSrc == SRC_CH1) ? SRC_VALID[1] : SRC_VALID[0];
  assign xfer          = (state == ST_LOAD) && FFT_BUF_READY && selValid;
  assign FFT_DATAI_VAL = xfer;
  assign SRC_POP       = {xfer && (curSrc == SRC_CH1), xfer && (curSrc == SRC_CH0)};
  assign FFT_DATAI     = !xfer ? '0 : ((curSrc == SRC_CH1) ? SRC1_DATA : SRC0_DATA);
  assign tagPush       = xfer && (inCnt == LAST_IDX);
  assign BUSY          = (state != ST_IDLE) || !tagEmpty;

  // ---- load side: arbitration and frame load ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      curSrc  <= SRC_CH1;        // so the first contested grant goes to ch0
      inCnt   <= '0;
      SRC_GNT <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if ((|SRC_REQ) && !tagFull) begin
            curSrc <= pick;
            state  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          SRC_GNT <= (curSrc == SRC_CH1) ? 2'b10 : 2'b01;
          state   <= ST_LOAD;
        end
        ST_LOAD: begin
          if (xfer) begin
            if (inCnt == LAST_IDX) begin
              inCnt   <= '0;
              SRC_GNT <= '0;
              state   <= ST_IDLE;
            end else begin
              inCnt <= inCnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FFT_SCHED_WDOG_EN
  logic [15:0] wdogCnt;

  assign wdogFire = (wdogCnt == 16'hFFFF) && !tagEmpty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdogCnt <= '0;
    end else if (tagEmpty || FFT_DATAO_VAL || wdogFire) begin
      wdogCnt <= '0;
    end else begin
      wdogCnt <= wdogCnt + 1'b1;
    end
  end
`else
  assign wdogFire = 1'b0;
`endif

  // An early OUTP_READY fall aborts the frame; it wins over a coincident sample.
  assign shortErr  = outpRdy_p1 && !FFT_OUTP_RDY && (outCnt != '0);
  assign frameDone = FFT_DATAO_VAL && (outCnt == LAST_IDX) && !shortErr && !wdogFire;
  assign tagPop    = shortErr || frameDone || wdogFire;

  // ---- result side: one register stage after the core ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      outpRdy_p1    <= 1'b0;
      FFT_READ_OUTP <= 1'b0;
      RES_VALID     <= 1'b0;
      RES_DATA      <= '0;
      RES_TAG       <= 1'b0;
      RES_LAST      <= 1'b0;
      ERR_SHORT     <= 1'b0;
      outCnt        <= '0;
    end else begin
      outpRdy_p1    <= FFT_OUTP_RDY;
      FFT_READ_OUTP <= !tagEmpty && RES_READY;
      RES_VALID     <= FFT_DATAO_VAL;
      RES_DATA      <= FFT_DATAO;
      RES_TAG       <= tagHead;   // captured before the pop that ends the frame
      RES_LAST      <= frameDone;
      ERR_SHORT     <= shortErr || wdogFire;
      if (shortErr || wdogFire) begin
        outCnt <= '0;
      end else if (FFT_DATAO_VAL) begin
        outCnt <= (outCnt == LAST_IDX) ? '0 : outCnt + 1'b1;
      end
    end
  end

  fft_tag_fifo #(
    .DEPTH (TAGDEPTH)
  ) u_tagFifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (tagPush),
    .pop   (tagPop),
    .din   (curSrc),
    .full  (tagFull),
    .empty (tagEmpty),
    .head  (tagHead)
  );

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler (POINTS=32, WIDTH=18, TAGDEPTH=2).
// The reference model tracks the round-robin history and a queue of expected result tags.
module tb_fft_frame_scheduler;

  localparam int POINTS = 32;
  localparam int WIDTH  = 18;
  localparam int W2     = 2 * WIDTH;

  logic          CLK = 1'b0;
  logic          RST;
  logic [1:0]    SRC_REQ, SRC_VALID, SRC_GNT, SRC_POP;
  logic [W2-1:0] SRC0_DATA, SRC1_DATA, FFT_DATAI, FFT_DATAO, RES_DATA;
  logic          FFT_BUF_READY, FFT_DATAI_VAL, FFT_OUTP_RDY, FFT_READ_OUTP, FFT_DATAO_VAL;
  logic          RES_READY, RES_VALID, RES_TAG, RES_LAST, ERR_SHORT, BUSY;

  int checks = 0;
  int errors = 0;
  bit tagQ[$];      // source IDs of frames loaded but not yet returned
  bit lastGrantM;   // channel granted most recently (1 after reset: ch0 favoured)

  always #5 CLK = ~CLK;

  fft_frame_scheduler #(.POINTS(POINTS), .WIDTH(WIDTH), .TAGDEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .SRC_REQ(SRC_REQ), .SRC_VALID(SRC_VALID),
    .SRC0_DATA(SRC0_DATA), .SRC1_DATA(SRC1_DATA), .SRC_GNT(SRC_GNT), .SRC_POP(SRC_POP),
    .FFT_BUF_READY(FFT_BUF_READY), .FFT_DATAI_VAL(FFT_DATAI_VAL), .FFT_DATAI(FFT_DATAI),
    .FFT_OUTP_RDY(FFT_OUTP_RDY), .FFT_READ_OUTP(FFT_READ_OUTP),
    .FFT_DATAO_VAL(FFT_DATAO_VAL), .FFT_DATAO(FFT_DATAO), .RES_READY(RES_READY),
    .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .RES_TAG(RES_TAG), .RES_LAST(RES_LAST),
    .ERR_SHORT(ERR_SHORT), .BUSY(BUSY)
  );

  function automatic logic [W2-1:0] rnd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W2-1:0];
  endfunction

  function automatic logic [82:0] allOuts();
    return {SRC_GNT, SRC_POP, FFT_DATAI_VAL, FFT_DATAI, FFT_READ_OUTP, RES_VALID,
            RES_DATA, RES_TAG, RES_LAST, ERR_SHORT, BUSY};
  endfunction

  task automatic idle_inputs();
    SRC_REQ       = 2'b00;
    SRC_VALID     = 2'b00;
    FFT_BUF_READY = 1'b0;
    FFT_DATAO_VAL = 1'b0;
    FFT_OUTP_RDY  = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Request a frame from 'req', stream up to stopAt samples (optionally stalling
  // BUF_READY for stallLen cycles once stallAt samples are in), report cycles spent.
  task automatic run_load(input logic [1:0] req, input int stallAt, input int stallLen,
                          input bit randValid, input int stopAt, output int span);
    bit expCh, granted, inGap, expXfer;
    logic [1:0] expGnt;
    int got, cyc, stalled;
    expCh   = (req == 2'b11) ? ~lastGrantM : req[1];
    expGnt  = expCh ? 2'b10 : 2'b01;
    SRC_REQ = req;
    granted = 1'b0;
    span    = 0;
    for (int i = 0; i < 20 && !granted; i++) begin
      if (SRC_GNT != 2'b00) granted = 1'b1;
      else tick();
    end
    checks++;
    if (!granted) begin
      errors++;
      $display("FAIL grant_timeout gnt=%b want=%b", SRC_GNT, expGnt);
      idle_inputs();
      return;
    end
    checks++;
    if (SRC_GNT !== expGnt) begin
      errors++;
      $display("FAIL grant_rr got=%b want=%b", SRC_GNT, expGnt);
    end
    lastGrantM = expCh;
    got = 0; cyc = 0; stalled = 0;
    while (got < stopAt && cyc < 400) begin
      SRC0_DATA     = rnd();
      SRC1_DATA     = rnd();
      inGap         = (got == stallAt) && (stalled < stallLen);
      FFT_BUF_READY = !inGap;
      SRC_VALID     = randValid ? 2'($urandom) : 2'b11;
      #1;
      expXfer = !inGap && SRC_VALID[expCh];
      checks++;
      if (FFT_DATAI_VAL !== expXfer) begin
        errors++;
        $display("FAIL datai_val sample=%0d got=%b want=%b", got, FFT_DATAI_VAL, expXfer);
      end
      if (expXfer) begin
        checks++;
        if (FFT_DATAI !== (expCh ? SRC1_DATA : SRC0_DATA) || SRC_POP !== expGnt) begin
          errors++;
          $display("FAIL datai sample=%0d got=%h pop=%b want=%h pop=%b", got, FFT_DATAI,
                   SRC_POP, expCh ? SRC1_DATA : SRC0_DATA, expGnt);
        end
        got++;
      end
      if (inGap) stalled++;
      tick();
      cyc++;
    end
    span = cyc;
    checks++;
    if (got < stopAt) begin
      errors++;
      $display("FAIL load_timeout got=%0d want=%0d", got, stopAt);
    end
    if (stopAt == POINTS) begin
      tagQ.push_back(expCh);
      checks++;
      if (SRC_GNT !== 2'b00 || BUSY !== 1'b1) begin
        errors++;
        $display("FAIL load_end gnt=%b busy=%b want gnt=00 busy=1", SRC_GNT, BUSY);
      end
      idle_inputs();
    end
  endtask

  // Play the core returning n result samples (with random gaps) for the head tag.
  task automatic run_output(input int n);
    bit expTag, gap;
    logic [W2-1:0] d;
    int i;
    checks++;
    if (tagQ.size() == 0) begin
      errors++;
      $display("FAIL output_no_tag pending=0 want>0");
      return;
    end
    expTag       = tagQ[0];
    RES_READY    = 1'b1;
    FFT_OUTP_RDY = 1'b1;
    tick();
    checks++;
    if (FFT_READ_OUTP !== 1'b1) begin
      errors++;
      $display("FAIL read_outp got=%b want=1", FFT_READ_OUTP);
    end
    i = 0;
    while (i < n) begin
      gap           = ($urandom_range(0, 3) == 0);
      d             = rnd();
      FFT_DATAO_VAL = !gap;
      FFT_DATAO     = d;
      tick();
      checks++;
      if (gap) begin
        if (RES_VALID !== 1'b0) begin
          errors++;
          $display("FAIL res_gap got valid=%b want 0", RES_VALID);
        end
      end else begin
        if (RES_VALID !== 1'b1 || RES_DATA !== d || RES_TAG !== expTag ||
            RES_LAST !== (i == POINTS - 1) || ERR_SHORT !== 1'b0) begin
          errors++;
          $display("FAIL res_sample i=%0d got v=%b d=%h tag=%b last=%b err=%b want v=1 d=%h tag=%b last=%b err=0",
                   i, RES_VALID, RES_DATA, RES_TAG, RES_LAST, ERR_SHORT, d, expTag,
                   (i == POINTS - 1));
        end
        i++;
      end
    end
    FFT_DATAO_VAL = 1'b0;
    FFT_OUTP_RDY  = 1'b0;
    void'(tagQ.pop_front());
    tick();
    checks++;
    if (ERR_SHORT !== (n < POINTS)) begin
      errors++;
      $display("FAIL err_short n=%0d got=%b want=%b", n, ERR_SHORT, (n < POINTS));
    end
    tick();
    checks++;
    if (ERR_SHORT !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse_width got=%b want=0", ERR_SHORT);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (BUSY !== 1'b0 || FFT_READ_OUTP !== 1'b0) begin
      errors++;
      $display("FAIL %s busy=%b read=%b want 0 0", name, BUSY, FFT_READ_OUTP);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      SRC_REQ       = 2'($urandom);
      SRC_VALID     = 2'($urandom);
      FFT_BUF_READY = 1'($urandom);
      SRC0_DATA     = rnd();
      SRC1_DATA     = rnd();
      FFT_DATAO_VAL = 1'($urandom);
      FFT_DATAO     = rnd();
      FFT_OUTP_RDY  = 1'($urandom);
      RES_READY     = 1'($urandom);
      tick();
      checks++;
      if (allOuts() !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle=%0d got=%h want=0", i, allOuts());
      end
    end
    idle_inputs();
    RES_READY = 1'b0;
    RST = 1'b0;
    tick();
    checks++;
    if (BUSY !== 1'b0 || SRC_GNT !== 2'b00 || FFT_READ_OUTP !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy=%b gnt=%b read=%b want 0", BUSY, SRC_GNT, FFT_READ_OUTP);
    end
    lastGrantM = 1'b1;
    tagQ.delete();
  endtask

  task automatic test_single_load();
    int span;
    run_load(2'b01, -1, 0, 1'b0, POINTS, span);
    checks++;
    if (span != POINTS) begin
      errors++;
      $display("FAIL single_span got=%0d want=%0d", span, POINTS);
    end
    run_output(POINTS);
    check_drained("single_drained");
  endtask

  task automatic test_round_robin();
    int span;
    run_load(2'b11, -1, 0, 1'b0, POINTS, span);
    run_load(2'b11, -1, 0, 1'b0, POINTS, span);
    SRC_REQ = 2'b11;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (SRC_GNT !== 2'b00 || BUSY !== 1'b1) begin
        errors++;
        $display("FAIL rr_full_block cycle=%0d gnt=%b busy=%b want gnt=00 busy=1", i, SRC_GNT, BUSY);
      end
    end
    run_output(POINTS);
    run_load(2'b11, -1, 0, 1'b0, POINTS, span);
    run_output(POINTS);
    run_output(POINTS);
    check_drained("rr_drained");
  endtask

  task automatic test_stall();
    int span;
    run_load(2'($urandom_range(1, 3)), 10, 5, 1'b0, POINTS, span);
    checks++;
    if (span != POINTS + 5) begin
      errors++;
      $display("FAIL stall_span got=%0d want=%0d", span, POINTS + 5);
    end
    FFT_BUF_READY = 1'b1;
    SRC_VALID     = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (FFT_DATAI_VAL !== 1'b0 || SRC_POP !== 2'b00) begin
        errors++;
        $display("FAIL extra_sample cycle=%0d val=%b pop=%b want 0", i, FFT_DATAI_VAL, SRC_POP);
      end
      tick();
    end
    idle_inputs();
    run_output(POINTS);
    check_drained("stall_drained");
  endtask

  task automatic test_short_frame();
    int span;
    for (int k = 0; k < 2; k++) run_load(2'($urandom_range(1, 3)), -1, 0, 1'b1, POINTS, span);
    RES_READY = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (FFT_READ_OUTP !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL read_without_ready read=%b busy=%b want read=0 busy=1", FFT_READ_OUTP, BUSY);
    end
    run_output(20);
    run_output(POINTS);
    check_drained("short_drained");
  endtask

  task automatic test_reset_midframe();
    int span;
    RES_READY = 1'b1;
    run_load(2'b10, -1, 0, 1'b0, POINTS, span);
    run_load(2'b01, -1, 0, 1'b0, 15, span);
    RST = 1'b1;
    #1;
    checks++;
    if (allOuts() !== '0) begin
      errors++;
      $display("FAIL midframe_reset got=%h want=0", allOuts());
    end
    tagQ.delete();
    lastGrantM = 1'b1;
    idle_inputs();
    tick();
    RST = 1'b0;
    run_load(2'b11, -1, 0, 1'b0, POINTS, span);
    checks++;
    if (span != POINTS) begin
      errors++;
      $display("FAIL after_reset_span got=%0d want=%0d", span, POINTS);
    end
    run_output(POINTS);
    check_drained("reset_drained");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1;
    idle_inputs();
    RES_READY = 1'b0;
    SRC0_DATA = '0;
    SRC1_DATA = '0;
    FFT_DATAO = '0;
    tick();
    test_reset();
    test_single_load();
    test_round_robin();
    test_stall();
    test_short_frame();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
